// File: rtl/dp_capture_pkg.sv
// Shared types and helpers for the datapath result capture block.
package dp_capture_pkg;

    localparam int DEFAULT_W = 32;

    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    typedef struct packed {
        logic signed [DEFAULT_W-1:0] x;
        logic signed [DEFAULT_W-1:0] z;
    } result_pair_t;

endpackage

// File: rtl/dp_sync_fifo.sv
// Show-ahead synchronous FIFO: head is visible on rdata the cycle after it is written.
module dp_sync_fifo
    import dp_capture_pkg::*;
#(
    parameter int DW    = 64,
    parameter int DEPTH = 8,
    localparam int CW   = count_width(DEPTH),
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign do_pop  = pop && !empty;
    // When full, a same-cycle pop frees the slot being overwritten (wr_ptr == rd_ptr).
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge Clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/dp_result_capture.sv
// Aligns upstream x/z results with their launch and buffers them behind valid/ready.
// Optional DP_CAPTURE_STATS_EN adds captured/dropped counters.
module dp_result_capture
    import dp_capture_pkg::*;
#(
    parameter int LATENCY = 2,
    parameter int DEPTH   = 8,
    parameter int W       = 32
) (
    input  logic                          Clk,
    input  logic                          Rst,
    input  logic                          in_valid,
    input  logic signed [W-1:0]           x_in,
    input  logic signed [W-1:0]           z_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [W-1:0]           out_x,
    output logic signed [W-1:0]           out_z,
    output logic [count_width(DEPTH)-1:0] count,
    output logic                          full,
    output logic                          empty,
    output logic                          drop
`ifdef DP_CAPTURE_STATS_EN
    ,
    output logic [31:0]                   captured_cnt,
    output logic [15:0]                   dropped_cnt
`endif
);

    // Handshake: a pair transfers in every cycle with out_valid && out_ready;
    // out_valid never depends on out_ready and the head holds while stalled.

    logic [LATENCY-1:0] tag;
    logic               push_req;
    logic               pop;
    logic               push;
    logic               drop_q;
    logic [2*W-1:0]     head;

    assign push_req  = tag[LATENCY-1];
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign push      = push_req && (!full || pop);
    assign drop      = drop_q;
    assign out_x     = head[2*W-1:W];
    assign out_z     = head[W-1:0];

    // Reset clears in-flight tags so pre-reset launches never land in the FIFO.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            tag    <= '0;
            drop_q <= 1'b0;
        end else begin
            tag[0] <= in_valid;
            for (int i = 1; i < LATENCY; i++) begin
                tag[i] <= tag[i-1];
            end
            drop_q <= push_req && full && !pop;
        end
    end

    dp_sync_fifo #(
        .DW    (2*W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .Clk   (Clk),
        .Rst   (Rst),
        .push  (push),
        .pop   (pop),
        .wdata ({x_in, z_in}),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

`ifdef DP_CAPTURE_STATS_EN
    always_ff @(posedge Clk) begin
        if (Rst) begin
            captured_cnt <= '0;
            dropped_cnt  <= '0;
        end else begin
            if (push) captured_cnt <= captured_cnt + 32'd1;
            if (push_req && full && !pop && (dropped_cnt != 16'hFFFF)) begin
                dropped_cnt <= dropped_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dp_result_capture.sv
// Directed self-checking bench for dp_result_capture (LATENCY=2, DEPTH=8, W=32).
module tb_dp_result_capture;
    import dp_capture_pkg::*;

    localparam int LAT = 2;
    localparam int DEP = 8;
    localparam int W   = 32;
    localparam int CW  = count_width(DEP);

    logic                Clk = 1'b0;
    logic                Rst;
    logic                in_valid;
    logic signed [W-1:0] x_in;
    logic signed [W-1:0] z_in;
    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] out_x;
    logic signed [W-1:0] out_z;
    logic [CW-1:0]       count;
    logic                full;
    logic                empty;
    logic                drop;
`ifdef DP_CAPTURE_STATS_EN
    logic [31:0]         captured_cnt;
    logic [15:0]         dropped_cnt;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    // Upstream model: history of launched operands, hx[LAT-1] is the one aligning now.
    logic signed [W-1:0] hx [LAT];
    logic signed [W-1:0] hz [LAT];
    result_pair_t        exp_q [$];

    always #5 Clk = ~Clk;

    dp_result_capture #(.LATENCY(LAT), .DEPTH(DEP), .W(W)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .in_valid  (in_valid),
        .x_in      (x_in),
        .z_in      (z_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_z     (out_z),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .drop      (drop)
`ifdef DP_CAPTURE_STATS_EN
        ,
        .captured_cnt (captured_cnt),
        .dropped_cnt  (dropped_cnt)
`endif
    );

    // One clock cycle: present inputs, take the edge, then advance the upstream history.
    task automatic cyc(input logic iv, input logic signed [W-1:0] xv,
                       input logic signed [W-1:0] zv, input logic rdy);
        in_valid  = iv;
        out_ready = rdy;
        x_in      = hx[LAT-1];
        z_in      = hz[LAT-1];
        @(posedge Clk);
        #1;
        for (int k = LAT - 1; k > 0; k--) begin
            hx[k] = hx[k-1];
            hz[k] = hz[k-1];
        end
        hx[0] = xv;
        hz[0] = zv;
    endtask

    task automatic do_reset();
        Rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x_in      = '0;
        z_in      = '0;
        for (int k = 0; k < LAT; k++) begin
            hx[k] = '0;
            hz[k] = '0;
        end
        @(posedge Clk);
        @(posedge Clk);
        #1;
        Rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        n_cmp++; if (out_x !== 32'sd0) begin n_fail++; $display("FAIL reset_out_x: got %0d want 0", out_x); end
        n_cmp++; if (out_z !== 32'sd0) begin n_fail++; $display("FAIL reset_out_z: got %0d want 0", out_z); end
        n_cmp++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
        n_cmp++; if (empty !== 1'b1 || full !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got empty=%0b full=%0b want 1/0", empty, full); end
        n_cmp++; if (drop !== 1'b0) begin n_fail++; $display("FAIL reset_drop: got %0b want 0", drop); end
`ifdef DP_CAPTURE_STATS_EN
        n_cmp++; if (captured_cnt !== 32'd0 || dropped_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_stats: got %0d/%0d want 0/0", captured_cnt, dropped_cnt); end
`endif
    endtask

    task automatic test_single();
        do_reset();
        cyc(1'b1, -32'sd7, 32'sd12, 1'b1);   // cycle 0 launch
        cyc(1'b0, '0, '0, 1'b1);             // cycle 1
        // cycle 2: result aligns now but must not pass through this cycle
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_no_passthru: got %0b want 0", out_valid); end
        cyc(1'b0, '0, '0, 1'b1);             // cycle 2 push
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %0b want 1", out_valid); end
        n_cmp++; if (out_x !== -32'sd7) begin n_fail++; $display("FAIL single_x: got %0d want -7", out_x); end
        n_cmp++; if (out_z !== 32'sd12) begin n_fail++; $display("FAIL single_z: got %0d want 12", out_z); end
        n_cmp++; if (count !== 4'd1) begin n_fail++; $display("FAIL single_count3: got %0d want 1", count); end
        cyc(1'b0, '0, '0, 1'b1);             // cycle 3 pop
        n_cmp++; if (count !== 4'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL single_count4: got count=%0d empty=%0b want 0/1", count, empty); end
        n_cmp++; if (out_x !== 32'sd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL single_empty_out: got x=%0d v=%0b want 0/0", out_x, out_valid); end
    endtask

    task automatic test_fill_drop();
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            cyc(1'b1, W'(i), W'(100 + i), 1'b0);
        end
        cyc(1'b0, '0, '0, 1'b0);             // cycle 9: 8th result pushes
        n_cmp++; if (count !== 4'd8 || full !== 1'b1) begin n_fail++; $display("FAIL fill_full: got count=%0d full=%0b want 8/1", count, full); end
        n_cmp++; if (drop !== 1'b0) begin n_fail++; $display("FAIL fill_drop_early: got %0b want 0", drop); end
        cyc(1'b0, '0, '0, 1'b0);             // cycle 10: 9th result lost
        n_cmp++; if (drop !== 1'b1) begin n_fail++; $display("FAIL fill_drop_pulse: got %0b want 1", drop); end
        n_cmp++; if (count !== 4'd8) begin n_fail++; $display("FAIL fill_count_hold: got %0d want 8", count); end
        cyc(1'b0, '0, '0, 1'b0);
        n_cmp++; if (drop !== 1'b0) begin n_fail++; $display("FAIL fill_drop_once: got %0b want 0", drop); end
        n_cmp++; if (out_x !== 32'sd1) begin n_fail++; $display("FAIL fill_head_stable: got %0d want 1", out_x); end
`ifdef DP_CAPTURE_STATS_EN
        n_cmp++; if (captured_cnt !== 32'd8) begin n_fail++; $display("FAIL stats_captured: got %0d want 8", captured_cnt); end
        n_cmp++; if (dropped_cnt !== 16'd1) begin n_fail++; $display("FAIL stats_dropped: got %0d want 1", dropped_cnt); end
`endif
        for (int i = 1; i <= 8; i++) begin
            n_cmp++; if (out_valid !== 1'b1 || out_x !== W'(i) || out_z !== W'(100 + i)) begin
                n_fail++; $display("FAIL fill_drain: got v=%0b x=%0d z=%0d want 1/%0d/%0d", out_valid, out_x, out_z, i, 100 + i);
            end
            cyc(1'b0, '0, '0, 1'b1);
        end
        n_cmp++; if (empty !== 1'b1 || count !== 4'd0 || out_x !== 32'sd0) begin n_fail++; $display("FAIL fill_no_ninth: got empty=%0b count=%0d x=%0d want 1/0/0", empty, count, out_x); end
    endtask

    task automatic test_full_pop();
        int vals [8];
        vals = '{2, 3, 4, 5, 6, 7, 8, 99};
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, W'(i), -W'(i), 1'b0);
        end
        cyc(1'b1, 32'sd99, -32'sd99, 1'b0); // cycle 8 launch of 99
        cyc(1'b0, '0, '0, 1'b0);             // cycle 9
        cyc(1'b0, '0, '0, 1'b1);             // cycle 10: 99 aligns with a pop
        n_cmp++; if (drop !== 1'b0) begin n_fail++; $display("FAIL fullpop_drop: got %0b want 0", drop); end
        n_cmp++; if (count !== 4'd8 || full !== 1'b1) begin n_fail++; $display("FAIL fullpop_count: got count=%0d full=%0b want 8/1", count, full); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (out_valid !== 1'b1 || out_x !== W'(vals[i]) || out_z !== -W'(vals[i]) || drop !== 1'b0) begin
                n_fail++; $display("FAIL fullpop_drain: got v=%0b x=%0d z=%0d drop=%0b want 1/%0d/%0d/0", out_valid, out_x, out_z, drop, vals[i], -vals[i]);
            end
            cyc(1'b0, '0, '0, 1'b1);
        end
        n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL fullpop_empty: got %0b want 1", empty); end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        cyc(1'b1, 32'sd55, -32'sd55, 1'b1);  // cycle 0
        Rst = 1'b1;
        cyc(1'b1, 32'sd66, -32'sd66, 1'b1);  // cycle 1, reset sampled
        Rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            n_cmp++; if (out_valid !== 1'b0 || out_x !== 32'sd0 || count !== 4'd0) begin
                n_fail++; $display("FAIL midreset_no_push: got v=%0b x=%0d count=%0d want 0/0/0", out_valid, out_x, count);
            end
            cyc(1'b0, '0, '0, 1'b1);
        end
    endtask

    // Streams launches through the DUT and checks every transfer against exp_q.
    task automatic run_stream(input string name, input int n_launch, input int gap, input bit toggle);
        int launched;
        int c;
        logic iv;
        logic rdy;
        result_pair_t p;
        do_reset();
        exp_q.delete();
        launched = 0;
        c = 0;
        while ((launched < n_launch || exp_q.size() != 0) && c < 200) begin
            iv  = (launched < n_launch) && ((c % gap) == 0);
            rdy = toggle ? ((c % 2) == 0) : 1'b1;
            if (out_valid && rdy) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL %s_unexpected: got x=%0d with nothing expected", name, out_x);
                end else begin
                    p = exp_q.pop_front();
                    if (out_x !== p.x || out_z !== p.z) begin
                        n_fail++; $display("FAIL %s_order: got %0d/%0d want %0d/%0d", name, out_x, out_z, p.x, p.z);
                    end
                end
            end
            n_cmp++; if (drop !== 1'b0 || count > 4'(DEP)) begin n_fail++; $display("FAIL %s_flow: got drop=%0b count=%0d want 0/<=8", name, drop, count); end
            if (iv) begin
                p.x = W'(1000 + launched);
                p.z = -W'(2000 + launched);
                exp_q.push_back(p);
                launched++;
            end
            cyc(iv, p.x, p.z, rdy);
            c++;
        end
        n_cmp++; if (exp_q.size() != 0 || launched != n_launch) begin n_fail++; $display("FAIL %s_timeout: got %0d left want 0", name, exp_q.size()); end
        n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL %s_end_empty: got %0b want 1", name, empty); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_drop();
        test_full_pop();
        test_reset_midflight();
        run_stream("wrap", 20, 2, 1'b1);
        run_stream("back_to_back", 12, 1, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
